axil_regfile_responder: RTL and testbench

- AXI-Lite responder (slave) that exposes a bank of NUM_REGS read/write 32-bit registers to any AXI-Lite initiator (bench tasks, CPU bridge).
- Serves as the generic register endpoint for chip-control style blocks.
- Independent read and write channels, one outstanding transaction per direction, registered responses, SLVERR on out-of-range access.

---
 rtl/axil_regfile_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_axil_regfile_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_regfile_responder.sv
// AXI-Lite register bank responder with independent read/write channels.
// Optional byte-strobe support via macro AXIL_REGFILE_WSTRB_EN.
module axil_regfile_responder #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    NUM_REGS   = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   aw_addr,
   input  logic                    aw_valid,
   output logic                    aw_ready,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_strb,
   input  logic                    w_valid,
   output logic                    w_ready,
   output logic [1:0]              b_resp,
   output logic                    b_valid,
   input  logic                    b_ready,
   input  logic [ADDR_WIDTH-1:0]   ar_addr,
   input  logic                    ar_valid,
   output logic                    ar_ready,
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic [1:0]              r_resp,
   output logic                    r_valid,
   input  logic                    r_ready
);

   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int SW = DATA_WIDTH / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [ADDR_WIDTH-1:0] NREG = ADDR_WIDTH'(NUM_REGS);

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

   wstate_t               r_wstate;
   wstate_t               w_wstate_nxt;
   logic                  r_aw_got;
   logic                  r_w_got;
   logic [ADDR_WIDTH-1:0] r_awaddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [SW-1:0]         r_wstrb;

   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_aw_got_nxt;
   logic                  w_w_got_nxt;
   logic                  w_awready_nxt;
   logic                  w_wready_nxt;
   logic                  w_bvalid_nxt;
   logic [1:0]            w_bresp_nxt;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [ADDR_WIDTH-1:0] w_woff;
   logic [IW-1:0]         w_widx;
   logic                  w_win;
   logic [DATA_WIDTH-1:0] w_wdata_sel;
   logic [SW-1:0]         w_wstrb_sel;
   logic [DATA_WIDTH-1:0] w_wmerged;

   rstate_t               r_rstate;
   rstate_t               w_rstate_nxt;
   logic                  w_ar_hs;
   logic                  w_arready_nxt;
   logic                  w_rvalid_nxt;
   logic [1:0]            w_rresp_nxt;
   logic [DATA_WIDTH-1:0] w_rdata_nxt;
   logic [ADDR_WIDTH-1:0] w_roff;
   logic [IW-1:0]         w_ridx;
   logic                  w_rin;

   assign w_aw_hs = aw_valid & aw_ready;
   assign w_w_hs  = w_valid & w_ready;
   assign w_ar_hs = ar_valid & ar_ready;

   // The channel captured earlier is taken from its holding register.
   assign w_waddr     = r_aw_got ? r_awaddr : aw_addr;
   assign w_wdata_sel = r_w_got ? r_wdata : w_data;
   assign w_wstrb_sel = r_w_got ? r_wstrb : w_strb;

   assign w_woff = w_waddr - BASE_ADDR;
   assign w_widx = w_woff[IW+1:2];
   assign w_win  = (w_waddr >= BASE_ADDR) && ((w_woff >> 2) < NREG);

   assign w_roff = ar_addr - BASE_ADDR;
   assign w_ridx = w_roff[IW+1:2];
   assign w_rin  = (ar_addr >= BASE_ADDR) && ((w_roff >> 2) < NREG);

`ifdef AXIL_REGFILE_WSTRB_EN
   // Merge strobed bytes of the new data into the current word.
   always_comb begin
      w_wmerged = r_regs[w_widx];
      for (int b = 0; b < SW; b++) begin
         if (w_wstrb_sel[b]) w_wmerged[8*b +: 8] = w_wdata_sel[8*b +: 8];
      end
   end
`else
   logic w_unused_strb;
   assign w_unused_strb = ^w_wstrb_sel;
   // Strobes ignored: every write replaces the whole word.
   always_comb begin
      w_wmerged = w_wdata_sel;
   end
`endif

   // Write FSM next-state and response logic.
   always_comb begin
      w_wstate_nxt  = r_wstate;
      w_aw_got_nxt  = r_aw_got;
      w_w_got_nxt   = r_w_got;
      w_awready_nxt = aw_ready;
      w_wready_nxt  = w_ready;
      w_bvalid_nxt  = b_valid;
      w_bresp_nxt   = b_resp;
      w_we          = 1'b0;
      unique case (r_wstate)
         W_IDLE: begin
            w_aw_got_nxt  = r_aw_got | w_aw_hs;
            w_w_got_nxt   = r_w_got | w_w_hs;
            w_awready_nxt = ~w_aw_got_nxt;
            w_wready_nxt  = ~w_w_got_nxt;
            if (w_aw_got_nxt && w_w_got_nxt) begin
               w_wstate_nxt  = W_RESP;
               w_awready_nxt = 1'b0;
               w_wready_nxt  = 1'b0;
               w_bvalid_nxt  = 1'b1;
               w_bresp_nxt   = w_win ? RESP_OKAY : RESP_SLVERR;
               w_we          = w_win;
            end
         end
         W_RESP: begin
            if (b_valid && b_ready) begin
               w_wstate_nxt  = W_IDLE;
               w_aw_got_nxt  = 1'b0;
               w_w_got_nxt   = 1'b0;
               w_awready_nxt = 1'b1;
               w_wready_nxt  = 1'b1;
               w_bvalid_nxt  = 1'b0;
            end
         end
      endcase
   end

   // Write FSM state, channel capture and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wstate <= W_IDLE;
         r_aw_got <= 1'b0;
         r_w_got  <= 1'b0;
         r_awaddr <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         aw_ready <= 1'b0;
         w_ready  <= 1'b0;
         b_valid  <= 1'b0;
         b_resp   <= RESP_OKAY;
      end else begin
         r_wstate <= w_wstate_nxt;
         r_aw_got <= w_aw_got_nxt;
         r_w_got  <= w_w_got_nxt;
         if (w_aw_hs) r_awaddr <= aw_addr;
         if (w_w_hs) begin
            r_wdata <= w_data;
            r_wstrb <= w_strb;
         end
         aw_ready <= w_awready_nxt;
         w_ready  <= w_wready_nxt;
         b_valid  <= w_bvalid_nxt;
         b_resp   <= w_bresp_nxt;
      end
   end

   // Register bank storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_we) begin
         r_regs[w_widx] <= w_wmerged;
      end
   end

   // Read FSM next-state and response logic.
   always_comb begin
      w_rstate_nxt  = r_rstate;
      w_arready_nxt = ar_ready;
      w_rvalid_nxt  = r_valid;
      w_rresp_nxt   = r_resp;
      w_rdata_nxt   = r_data;
      unique case (r_rstate)
         R_IDLE: begin
            w_arready_nxt = 1'b1;
            if (w_ar_hs) begin
               w_rstate_nxt  = R_DATA;
               w_arready_nxt = 1'b0;
               w_rvalid_nxt  = 1'b1;
               w_rresp_nxt   = w_rin ? RESP_OKAY : RESP_SLVERR;
               w_rdata_nxt   = w_rin ? r_regs[w_ridx] : '0;
            end
         end
         R_DATA: begin
            if (r_valid && r_ready) begin
               w_rstate_nxt  = R_IDLE;
               w_arready_nxt = 1'b1;
               w_rvalid_nxt  = 1'b0;
            end
         end
      endcase
   end

   // Read FSM state and registered read response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rstate <= R_IDLE;
         ar_ready <= 1'b0;
         r_valid  <= 1'b0;
         r_resp   <= RESP_OKAY;
         r_data   <= '0;
      end else begin
         r_rstate <= w_rstate_nxt;
         ar_ready <= w_arready_nxt;
         r_valid  <= w_rvalid_nxt;
         r_resp   <= w_rresp_nxt;
         r_data   <= w_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_axil_regfile_responder.sv
// Randomised bench for axil_regfile_responder against an array-based
// register model; honours AXIL_REGFILE_WSTRB_EN when defined.
module tb_axil_regfile_responder;

   localparam logic [31:0] BASE = 32'h40;
   localparam int          NREG = 8;
   localparam logic [1:0]  OKAY = 2'b00;
   localparam logic [1:0]  SLVE = 2'b10;

   logic        clk;
   logic        rst_n;
   logic [31:0] aw_addr;
   logic        aw_valid;
   logic        aw_ready;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        w_valid;
   logic        w_ready;
   logic [1:0]  b_resp;
   logic        b_valid;
   logic        b_ready;
   logic [31:0] ar_addr;
   logic        ar_valid;
   logic        ar_ready;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_valid;
   logic        r_ready;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [NREG];

   axil_regfile_responder #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .NUM_REGS  (NREG),
      .BASE_ADDR (BASE)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .aw_addr (aw_addr),
      .aw_valid(aw_valid),
      .aw_ready(aw_ready),
      .w_data  (w_data),
      .w_strb  (w_strb),
      .w_valid (w_valid),
      .w_ready (w_ready),
      .b_resp  (b_resp),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .ar_addr (ar_addr),
      .ar_valid(ar_valid),
      .ar_ready(ar_ready),
      .r_data  (r_data),
      .r_resp  (r_resp),
      .r_valid (r_valid),
      .r_ready (r_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit m_in(input logic [31:0] a);
      return (a >= BASE) && (((a - BASE) / 4) < NREG);
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a - BASE) / 4);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      return m_in(a) ? mem[m_idx(a)] : 32'h0;
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
      if (m_in(a)) begin
`ifdef AXIL_REGFILE_WSTRB_EN
         for (int b = 0; b < 4; b++)
            if (s[b]) mem[m_idx(a)][8*b +: 8] = d[8*b +: 8];
`else
         if (s !== 4'hx) mem[m_idx(a)] = d;
`endif
      end
   endtask

   task automatic m_clear();
      for (int i = 0; i < NREG; i++) mem[i] = 32'h0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called at a negedge with the bus idle; returns at a negedge.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int aw_dly,
                            input int w_dly, input int b_dly);
      bit          aw_done = 0;
      bit          w_done  = 0;
      bit          hs_aw;
      bit          hs_w;
      int          cyc = 0;
      logic [1:0]  exp_resp;
      exp_resp = m_in(a) ? OKAY : SLVE;
      while (!(aw_done && w_done) && cyc < 50) begin
         aw_valid = !aw_done && (cyc >= aw_dly);
         aw_addr  = a;
         w_valid  = !w_done && (cyc >= w_dly);
         w_data   = d;
         w_strb   = s;
         if (aw_done) check("aw_ready_held_low", aw_ready, 0);
         if (w_done) check("w_ready_held_low", w_ready, 0);
         hs_aw = aw_valid && aw_ready;
         hs_w  = w_valid && w_ready;
         step();
         if (hs_aw) aw_done = 1;
         if (hs_w) w_done = 1;
         cyc++;
      end
      aw_valid = 0;
      w_valid  = 0;
      if (!(aw_done && w_done)) begin
         check("write_hs_timeout", 0, 1);
         return;
      end
      m_write(a, d, s);
      check("b_valid_after_hs", b_valid, 1);
      check("b_resp", b_resp, exp_resp);
      for (int i = 0; i < b_dly; i++) begin
         step();
         check("b_valid_hold", b_valid, 1);
         check("b_resp_hold", b_resp, exp_resp);
         check("aw_ready_wait", aw_ready, 0);
         check("w_ready_wait", w_ready, 0);
      end
      b_ready = 1;
      step();
      b_ready = 0;
      check("b_valid_drop", b_valid, 0);
      check("aw_ready_back", aw_ready, 1);
      check("w_ready_back", w_ready, 1);
   endtask

   task automatic axi_read(input logic [31:0] a, input int r_dly);
      bit          done = 0;
      bit          hs;
      int          cyc = 0;
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      exp_d = m_read(a);
      exp_r = m_in(a) ? OKAY : SLVE;
      ar_addr  = a;
      ar_valid = 1;
      while (!done && cyc < 50) begin
         hs = ar_ready;
         step();
         if (hs) done = 1;
         cyc++;
      end
      ar_valid = 0;
      if (!done) begin
         check("read_hs_timeout", 0, 1);
         return;
      end
      check("r_valid", r_valid, 1);
      check("ar_ready_low", ar_ready, 0);
      check("r_data", r_data, exp_d);
      check("r_resp", r_resp, exp_r);
      for (int i = 0; i < r_dly; i++) begin
         step();
         check("r_data_hold", r_data, exp_d);
         check("r_valid_hold", r_valid, 1);
      end
      r_ready = 1;
      step();
      r_ready = 0;
      check("r_valid_drop", r_valid, 0);
      check("ar_ready_back", ar_ready, 1);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_s;
      rst_n    = 0;
      aw_addr  = 0;
      aw_valid = 0;
      w_data   = 0;
      w_strb   = 0;
      w_valid  = 0;
      b_ready  = 0;
      ar_addr  = 0;
      ar_valid = 0;
      r_ready  = 0;
      m_clear();

      repeat (2) @(negedge clk);
      check("rst_aw_ready", aw_ready, 0);
      check("rst_w_ready", w_ready, 0);
      check("rst_ar_ready", ar_ready, 0);
      check("rst_b_valid", b_valid, 0);
      check("rst_r_valid", r_valid, 0);
      check("rst_r_data", r_data, 0);
      rst_n = 1;
      step();
      check("first_ar_ready", ar_ready, 1);
      check("first_aw_ready", aw_ready, 1);
      check("first_w_ready", w_ready, 1);

      for (int i = 0; i < NREG; i++) axi_read(BASE + 32'(4 * i), 0);

      axi_write(BASE + 32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      axi_read(BASE + 32'h08, 1);

      axi_write(BASE + 32'h0C, 32'h12345678, 4'hF, 3, 0, 4);
      axi_read(BASE + 32'h0C, 0);

      axi_write(BASE + 32'h20, 32'hCAFEF00D, 4'hF, 0, 2, 1);
      axi_read(BASE + 32'h20, 0);
      axi_write(BASE - 32'h4, 32'h0BADF00D, 4'hF, 1, 0, 0);
      axi_read(BASE - 32'h4, 0);
      for (int i = 0; i < NREG; i++) axi_read(BASE + 32'(4 * i), 0);

      axi_write(BASE + 32'h0C, 32'h11111111, 4'hF, 0, 0, 0);
      aw_addr  = BASE + 32'h0C;
      w_data   = 32'h22222222;
      w_strb   = 4'hF;
      ar_addr  = BASE + 32'h0C;
      aw_valid = 1;
      w_valid  = 1;
      ar_valid = 1;
      step();
      aw_valid = 0;
      w_valid  = 0;
      ar_valid = 0;
      check("same_edge_r_valid", r_valid, 1);
      check("same_edge_old_data", r_data, 32'h11111111);
      check("same_edge_b_valid", b_valid, 1);
      m_write(BASE + 32'h0C, 32'h22222222, 4'hF);
      b_ready = 1;
      r_ready = 1;
      step();
      b_ready = 0;
      r_ready = 0;
      axi_read(BASE + 32'h0C, 0);
      check("same_edge_model", m_read(BASE + 32'h0C), 32'h22222222);

      axi_write(BASE + 32'h10, 32'h11223344, 4'hF, 0, 0, 0);
      axi_write(BASE + 32'h10, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
`ifdef AXIL_REGFILE_WSTRB_EN
      exp_s = 32'h11BB33DD;
`else
      exp_s = 32'hAABBCCDD;
`endif
      check("strb_model", m_read(BASE + 32'h10), exp_s);
      axi_read(BASE + 32'h10, 0);

      for (int it = 0; it < 60; it++) begin
         a = BASE - 32'h10 + 32'($urandom_range(0, 63));
         d = $urandom;
         if ($urandom_range(0, 1) == 1)
            axi_write(a, d, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3));
         else
            axi_read(a, $urandom_range(0, 2));
      end

      aw_addr  = BASE + 32'h4;
      w_data   = 32'h5A5A5A5A;
      w_strb   = 4'hF;
      aw_valid = 1;
      w_valid  = 1;
      ar_addr  = BASE + 32'h8;
      ar_valid = 1;
      step();
      aw_valid = 0;
      w_valid  = 0;
      ar_valid = 0;
      rst_n    = 0;
      #1;
      check("midrst_b_valid", b_valid, 0);
      check("midrst_r_valid", r_valid, 0);
      check("midrst_aw_ready", aw_ready, 0);
      m_clear();
      @(negedge clk);
      rst_n = 1;
      step();
      check("midrst_b_stays_low", b_valid, 0);
      axi_read(BASE + 32'h4, 0);
      axi_read(BASE + 32'h8, 0);
      axi_read(BASE + 32'h0C, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
